alu_shift_seq: RTL and testbench

Parametrised successor to the JAM-1 LHS shift unit. Shifts, rotates or zeroes a WIDTH-bit operand by a multi-bit amount.
- Default build is iterative: one bit per clock, with a start/busy/done handshake.
- Produces a registered result and carry.
- Sits between ALU operand select and the ALU result mux, replacing the single-bit shift stage when multi-bit shifts are issued.

---
 rtl/alu_shift_seq_if.sv | 30 +++
 rtl/alu_shift_seq.sv | 157 +++++++++++++++
 tb/tb_alu_shift_seq.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/alu_shift_seq_if.sv
// alu_shift_seq_if
// Groups the operation request and completion signals of alu_shift_seq.
//   master modport (requester): drives start/op/amount/carry_in/data_in,
//                               observes busy/done/result/carry_out.
//   slave modport  (shifter)  : the reverse.
// Parameters WIDTH/AMT_W must match the alu_shift_seq instance.
interface alu_shift_seq_if #(
  parameter int WIDTH = 8,
  parameter int AMT_W = $clog2(WIDTH + 1)
);
  logic             start;
  logic [2:0]       op;
  logic [AMT_W-1:0] amount;
  logic             carry_in;
  logic [WIDTH-1:0] data_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             carry_out;

  modport master (
    output start, op, amount, carry_in, data_in,
    input  busy, done, result, carry_out
  );

  modport slave (
    input  start, op, amount, carry_in, data_in,
    output busy, done, result, carry_out
  );
endinterface

// File: rtl/alu_shift_seq.sv
// alu_shift_seq
// Multi-bit shift/rotate/zero unit for the ALU operand path. The default
// build steps one bit per clock (start/busy/done handshake); defining the
// macro SHIFT_FAST_EN replaces the stepping with a combinational barrel
// shifter that completes on the accepting edge, with identical results.
// Ports:
//   clk - system clock, rising edge
//   rst - asynchronous active-high reset
//   bus - alu_shift_seq_if.slave: start, op[2:0], amount[AMT_W-1:0],
//         carry_in, data_in[WIDTH-1:0] in; busy, done, result[WIDTH-1:0],
//         carry_out out
// op: 0 PASS, 1 SHL, 2 SHR, 3 ZERO, 4 ROL, 5 ROR, 6 ASR, 7 PASS
module alu_shift_seq #(
  parameter int WIDTH = 8,
  parameter int AMT_W = $clog2(WIDTH + 1)
) (
  input logic           clk,
  input logic           rst,
  alu_shift_seq_if.slave bus
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  localparam logic [2:0] OP_PASS = 3'd0;
  localparam logic [2:0] OP_SHL  = 3'd1;
  localparam logic [2:0] OP_SHR  = 3'd2;
  localparam logic [2:0] OP_ZERO = 3'd3;
  localparam logic [2:0] OP_ROL  = 3'd4;
  localparam logic [2:0] OP_ROR  = 3'd5;
  localparam logic [2:0] OP_ASR  = 3'd6;
  localparam logic [2:0] OP_RSV  = 3'd7;

  // One bit-step; returns {carry, value}. SHL/SHR refill from the latched
  // carry_in on every step, not from the previous step's carry.
  function automatic logic [WIDTH:0] step_f(input logic [WIDTH-1:0] v,
                                            input logic [2:0]       o,
                                            input logic             ci);
    logic [WIDTH:0] r;
    case (o)
      OP_SHL:  r = {v[WIDTH-1], v[WIDTH-2:0], ci};
      OP_SHR:  r = {v[0], ci, v[WIDTH-1:1]};
      OP_ROL:  r = {v[WIDTH-1], v[WIDTH-2:0], v[WIDTH-1]};
      OP_ROR:  r = {v[0], v[0], v[WIDTH-1:1]};
      OP_ASR:  r = {v[0], v[WIDTH-1], v[WIDTH-1:1]};
      default: r = {1'b0, v};
    endcase
    return r;
  endfunction

`ifdef SHIFT_FAST_EN
  // Unrolled chain of single steps so fast results match iterative ones bit
  // for bit, including the carry from the final step.
  function automatic logic [WIDTH:0] barrel_f(input logic [WIDTH-1:0] v,
                                              input logic [2:0]       o,
                                              input logic             ci,
                                              input logic [AMT_W-1:0] n);
    logic [WIDTH:0] r;
    r = {1'b0, v};
    for (int i = 0; i < WIDTH; i++) begin
      if (i < int'(n)) r = step_f(r[WIDTH-1:0], o, ci);
    end
    return r;
  endfunction
`endif

  logic [1:0]       state_q,  state_d;
  logic [AMT_W-1:0] cnt_q,    cnt_d;
  logic [WIDTH-1:0] work_q,   work_d;
  logic [2:0]       op_q,     op_d;
  logic             cin_q,    cin_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             carry_q,  carry_d;

  logic [AMT_W-1:0] amt_clamp;
  logic             imm;
  logic [WIDTH:0]   step_v;

  always_comb begin
    amt_clamp = (bus.amount > AMT_W'(WIDTH)) ? AMT_W'(WIDTH) : bus.amount;
    // PASS/ZERO/reserved and zero-distance shifts finish on the accepting edge
    imm = (amt_clamp == '0) || (bus.op == OP_PASS) || (bus.op == OP_ZERO) ||
          (bus.op == OP_RSV);
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    work_d   = work_q;
    op_d     = op_q;
    cin_d    = cin_q;
    result_d = result_q;
    carry_d  = carry_q;
    step_v   = step_f(work_q, op_q, cin_q);

    if (state_q == S_SHIFT) begin
      work_d = step_v[WIDTH-1:0];
      cnt_d  = cnt_q - AMT_W'(1);
      if (cnt_q == AMT_W'(1)) begin
        result_d = step_v[WIDTH-1:0];
        carry_d  = step_v[WIDTH];
        state_d  = S_DONE;
      end
    end else if (bus.start) begin
      work_d = bus.data_in;
      op_d   = bus.op;
      cin_d  = bus.carry_in;
      cnt_d  = amt_clamp;
      if (imm) begin
        result_d = (bus.op == OP_ZERO) ? '0 : bus.data_in;
        carry_d  = 1'b0;
        state_d  = S_DONE;
      end else begin
`ifdef SHIFT_FAST_EN
        {carry_d, result_d} = barrel_f(bus.data_in, bus.op, bus.carry_in,
                                       amt_clamp);
        state_d = S_DONE;
`else
        state_d = S_SHIFT;
`endif
      end
    end else begin
      state_d = S_IDLE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      work_q   <= '0;
      op_q     <= '0;
      cin_q    <= 1'b0;
      result_q <= '0;
      carry_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      work_q   <= work_d;
      op_q     <= op_d;
      cin_q    <= cin_d;
      result_q <= result_d;
      carry_q  <= carry_d;
    end
  end

`ifdef SHIFT_FAST_EN
  assign bus.busy = 1'b0;
`else
  assign bus.busy = (state_q == S_SHIFT);
`endif
  assign bus.done      = (state_q == S_DONE);
  assign bus.result    = result_q;
  assign bus.carry_out = carry_q;

endmodule

// File: tb/tb_alu_shift_seq.sv
module tb_alu_shift_seq;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;

  alu_shift_seq_if #(.WIDTH(W)) bus ();

  alu_shift_seq #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] op;
    logic [3:0] amt;
    logic       ci;
    logic [7:0] d;
    logic [7:0] res;
    logic       cy;
    int         n;
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference: whole-operand arithmetic on the clamped distance.
  function automatic void model(input int o, input int a, input int ci,
                                input int d, output int res, output int cy,
                                output int n);
    int mask;
    int s;
    mask = (1 << W) - 1;
    n = (a > W) ? W : a;
    res = d;
    cy = 0;
    if (o == 0 || o == 3 || o == 7 || n == 0) begin
      res = (o == 3) ? 0 : d;
      n = 0;
    end else begin
      case (o)
        1: begin
          res = ((d << n) | (ci != 0 ? ((1 << n) - 1) : 0)) & mask;
          cy  = (d >> (W - n)) & 1;
        end
        2: begin
          res = (d >> n) | (ci != 0 ? (mask & ~(mask >> n)) : 0);
          cy  = (d >> (n - 1)) & 1;
        end
        4: begin
          res = ((d << n) | (d >> (W - n))) & mask;
          cy  = res & 1;
        end
        5: begin
          res = ((d >> n) | (d << (W - n))) & mask;
          cy  = (res >> (W - 1)) & 1;
        end
        default: begin
          s   = (d >= (1 << (W - 1))) ? d - (1 << W) : d;
          res = (s >>> n) & mask;
          cy  = (d >> (n - 1)) & 1;
        end
      endcase
    end
  endfunction

  function automatic int exp_lat(input int n);
`ifdef SHIFT_FAST_EN
    return 0 * n;
`else
    return n;
`endif
  endfunction

  task automatic drive(input int o, input int a, input int ci, input int d);
    bus.op       = 3'(o);
    bus.amount   = 4'(a);
    bus.carry_in = 1'(ci);
    bus.data_in  = 8'(d);
    bus.start    = 1'b1;
  endtask

  // Called at the negedge after the accepting edge with start already low.
  task automatic wait_done(input string nm, output int k, output int b);
    k = 0;
    b = 0;
    while (bus.done !== 1'b1 && k < 40) begin
      if (bus.busy === 1'b1) b++;
      @(negedge clk);
      k++;
    end
    if (bus.done !== 1'b1) chk({nm, "_timeout"}, 0, 1);
  endtask

  task automatic do_op(input string nm, input int o, input int a, input int ci,
                       input int d, output int k, output int b);
    @(negedge clk);
    drive(o, a, ci, d);
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(nm, k, b);
  endtask

  task automatic verify(input string nm, input int k, input int b,
                        input int eres, input int ecy, input int en);
    chk({nm, "_result"}, int'(bus.result), eres);
    chk({nm, "_carry"}, int'(bus.carry_out), ecy);
    chk({nm, "_latency"}, k, exp_lat(en));
    chk({nm, "_busy_cycles"}, b, exp_lat(en));
    @(negedge clk);
    chk({nm, "_done_pulse"}, int'(bus.done), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int k, b, r, c, n;
    vecs[0]  = '{3'd1, 4'd1,  1'b1, 8'hA5, 8'h4B, 1'b1, 1};
    vecs[1]  = '{3'd2, 4'd3,  1'b0, 8'hA5, 8'h14, 1'b1, 3};
    vecs[2]  = '{3'd4, 4'd4,  1'b0, 8'h3C, 8'hC3, 1'b1, 4};
    vecs[3]  = '{3'd5, 4'd4,  1'b0, 8'hC3, 8'h3C, 1'b0, 4};
    vecs[4]  = '{3'd6, 4'd8,  1'b0, 8'h80, 8'hFF, 1'b1, 8};
    vecs[5]  = '{3'd6, 4'd15, 1'b0, 8'h80, 8'hFF, 1'b1, 8};
    vecs[6]  = '{3'd3, 4'd5,  1'b1, 8'hFF, 8'h00, 1'b0, 0};
    vecs[7]  = '{3'd0, 4'd7,  1'b1, 8'h5A, 8'h5A, 1'b0, 0};
    vecs[8]  = '{3'd7, 4'd3,  1'b0, 8'h33, 8'h33, 1'b0, 0};
    vecs[9]  = '{3'd1, 4'd0,  1'b1, 8'h96, 8'h96, 1'b0, 0};
    vecs[10] = '{3'd1, 4'd8,  1'b0, 8'h81, 8'h00, 1'b1, 8};
    vecs[11] = '{3'd2, 4'd9,  1'b1, 8'h7E, 8'hFF, 1'b0, 8};

    bus.start = 1'b0;
    bus.op = '0;
    bus.amount = '0;
    bus.carry_in = 1'b0;
    bus.data_in = '0;

    // reset state
    repeat (2) @(negedge clk);
    chk("reset_busy", int'(bus.busy), 0);
    chk("reset_done", int'(bus.done), 0);
    chk("reset_result", int'(bus.result), 0);
    chk("reset_carry", int'(bus.carry_out), 0);
    rst = 1'b0;

    // directed table
    foreach (vecs[i]) begin
      do_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].amt, vecs[i].ci,
            vecs[i].d, k, b);
      verify($sformatf("vec%0d", i), k, b, vecs[i].res, vecs[i].cy, vecs[i].n);
    end

    // start pulsed mid-shift must be ignored
`ifndef SHIFT_FAST_EN
    @(negedge clk);
    drive(1, 5, 0, 8'h0F);
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    drive(3, 0, 0, 8'hFF);
    @(negedge clk);
    bus.start = 1'b0;
    wait_done("intrude", k, b);
    chk("intrude_result", int'(bus.result), 8'hE0);
    chk("intrude_carry", int'(bus.carry_out), 1);
    chk("intrude_remaining", k, 3);
    repeat (3) begin
      @(negedge clk);
      chk("intrude_no_queue", int'(bus.done), 0);
    end
    chk("intrude_held", int'(bus.result), 8'hE0);
`else
    do_op("intrude", 1, 5, 0, 8'h0F, k, b);
    verify("intrude", k, b, 8'hE0, 1, 5);
`endif

    // async reset mid-operation
    @(negedge clk);
    drive(1, 6, 1, 8'h55);
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_busy", int'(bus.busy), 0);
    chk("arst_done", int'(bus.done), 0);
    chk("arst_result", int'(bus.result), 0);
    chk("arst_carry", int'(bus.carry_out), 0);
    @(negedge clk);
    rst = 1'b0;
    do_op("post_rst", 2, 2, 1, 8'h0C, k, b);
    verify("post_rst", k, b, 8'hC3, 0, 2);

    // back-to-back start while done is high
    do_op("b2b_a", 1, 1, 0, 8'h01, k, b);
    chk("b2b_a_result", int'(bus.result), 8'h02);
    drive(5, 2, 0, 8'h01);
    @(negedge clk);
    bus.start = 1'b0;
    wait_done("b2b_b", k, b);
    verify("b2b_b", k, b, 8'h40, 0, 2);

    // randomized against the reference model
    for (int t = 0; t < 40; t++) begin
      int o, a, ci, d;
      o  = int'($urandom_range(0, 7));
      a  = int'($urandom_range(0, 15));
      ci = int'($urandom_range(0, 1));
      d  = int'($urandom_range(0, 255));
      model(o, a, ci, d, r, c, n);
      do_op($sformatf("rnd%0d", t), o, a, ci, d, k, b);
      verify($sformatf("rnd%0d_op%0d_a%0d_d%0h", t, o, a, d), k, b, r, c, n);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
